// File: rtl/pipe_scoreboard.sv
// Register scoreboard for issue: tracks pending fixed- and variable-latency writes per register.
// Optional SB_ZERO_REG_EN makes register 0 hardwired (RISC-V x0); otherwise r0 is tracked (ARM).
module pipe_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 8,
  parameter int LW      = 4,
  parameter int BYPASS  = 1,
  parameter int NVAR    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic          iss_use1,
  input  logic          iss_use2,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_rd,
  input  logic [LW-1:0] iss_lat,
  input  logic          iss_var,
  input  logic          flush,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  output logic          stall,
  output logic          iss_fire,
  output logic [LW-1:0] var_cnt,
  output logic          idle,
  output logic          err
);

`ifdef SB_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  localparam logic [LW-1:0] BypassLim = LW'(BYPASS);
  localparam logic [LW-1:0] MaxLat    = LW'(MAX_LAT);
  localparam logic [LW-1:0] NvarLim   = LW'(NVAR);

  logic [LW-1:0]    cnt_q [NREGS];
  logic [LW-1:0]    cnt_d [NREGS];
  logic [NREGS-1:0] vb_q, vb_d;
  logic [LW-1:0]    var_cnt_q, var_cnt_d;
  logic             err_q, err_d;

  logic rdy1, rdy2, wawBusy, varFull;
  logic varSet, wbClr, anyCnt;

  function automatic logic inRange(input logic [AW-1:0] r);
    return 32'(r) < NREGS;
  endfunction

  function automatic logic tracked(input logic [AW-1:0] r);
    return inRange(r) && !(ZeroReg && (r == '0));
  endfunction

  // Hazard checks look only at registered state; a wb this cycle releases dependents next cycle.
  always_comb begin
    rdy1     = !tracked(iss_rs1) || (!vb_q[iss_rs1] && (cnt_q[iss_rs1] <= BypassLim));
    rdy2     = !tracked(iss_rs2) || (!vb_q[iss_rs2] && (cnt_q[iss_rs2] <= BypassLim));
    wawBusy  = tracked(iss_rd) && ((cnt_q[iss_rd] != '0) || vb_q[iss_rd]);
    varFull  = (var_cnt_q == NvarLim);
    stall    = rst && iss_valid && ((iss_use1 && !rdy1) || (iss_use2 && !rdy2) ||
                                    (iss_we && wawBusy) || (iss_we && iss_var && varFull));
    iss_fire = rst && iss_valid && !stall && !flush;
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
    end
    vb_d      = vb_q;
    var_cnt_d = var_cnt_q;
    err_d     = err_q;
    varSet    = iss_fire && iss_we && iss_var && tracked(iss_rd);
    wbClr     = wb_valid && tracked(wb_rd) && vb_q[wb_rd];

    if (iss_fire && iss_we) begin
      if (!inRange(iss_rd)) begin
        err_d = 1'b1;
      end else if (tracked(iss_rd)) begin
        if (iss_var) begin
          vb_d[iss_rd] = 1'b1;
        end else if (iss_lat > MaxLat) begin
          cnt_d[iss_rd] = MaxLat;
          err_d         = 1'b1;
        end else if (iss_lat != '0) begin
          cnt_d[iss_rd] = iss_lat;
        end
      end
    end

    if (wb_valid) begin
      if (wbClr) begin
        vb_d[wb_rd] = 1'b0;
      end else if (!(ZeroReg && (wb_rd == '0))) begin
        err_d = 1'b1;
      end
    end

    // Issue and retire in the same cycle cancel out.
    case ({varSet, wbClr})
      2'b10:   var_cnt_d = var_cnt_q + LW'(1);
      2'b01:   var_cnt_d = var_cnt_q - LW'(1);
      default: var_cnt_d = var_cnt_q;
    endcase
  end

  always_comb begin
    anyCnt = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      anyCnt = anyCnt | (cnt_q[r] != '0);
    end
    idle    = !anyCnt && (var_cnt_q == '0);
    var_cnt = var_cnt_q;
    err     = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      vb_q      <= '0;
      var_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      vb_q      <= vb_d;
      var_cnt_q <= var_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule
